// File: rtl/mul_div_pkg.sv
// Shared definitions for the integer mul/div functional unit.
package mul_div_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  // RV32M funct3 encodings for the divide group
  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

endpackage

// File: rtl/div_sign_fix.sv
// Final quotient/remainder selection: special-case forcing and sign restoration.
module div_sign_fix
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic [WIDTH-1:0] q_raw,
  input  logic [WIDTH-1:0] r_raw,
  input  logic [WIDTH-1:0] dividend,
  input  logic             neg_q,
  input  logic             neg_r,
  input  logic             div_zero,
  input  logic             sign_ovf,
  output logic [WIDTH-1:0] quot_c,
  output logic [WIDTH-1:0] rem_c
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Divide-by-zero outranks overflow, which outranks the normal sign fix
  always_comb begin
    quot_c = q_raw;
    rem_c  = r_raw;
    if (div_zero) begin
      quot_c = '1;
      rem_c  = dividend;
    end else if (sign_ovf) begin
      quot_c = MIN_NEG;
      rem_c  = '0;
    end else begin
      quot_c = neg_q ? ('0 - q_raw) : q_raw;
      rem_c  = neg_r ? ('0 - r_raw) : r_raw;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip CALC entirely.
module seq_divider
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             is_signed,
  input  logic             start,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [WIDTH-1:0] r_q, q_q, d_mag_q, dividend_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q_q, neg_r_q, div_zero_q, sign_ovf_q;

  logic             a_neg_c, b_neg_c, div_zero_c, sign_ovf_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH-1:0] quot_c, rem_c;
  logic             load_c, step_c, finish_c;

  // Operand magnitudes and special-case detection on the incoming request
  assign a_neg_c    = is_signed & SrcA[WIDTH-1];
  assign b_neg_c    = is_signed & SrcB[WIDTH-1];
  assign a_mag_c    = a_neg_c ? ('0 - SrcA) : SrcA;
  assign b_mag_c    = b_neg_c ? ('0 - SrcB) : SrcB;
  assign div_zero_c = (SrcB == '0);
  assign sign_ovf_c = is_signed && (SrcA == MIN_NEG) && (SrcB == '1);

  // Full-width trial subtract so divisors above 2^(WIDTH-1) are handled
  assign trial_c = {r_q, q_q[WIDTH-1]} - {1'b0, d_mag_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_FAST_SPECIAL_EN
          state_nxt = (div_zero_c || sign_ovf_c) ? FIXUP : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (cnt_q == CW'(1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_c   = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state)
      IDLE:    load_c   = start;
      CALC:    step_c   = 1'b1;
      FIXUP:   finish_c = 1'b1;
      default: ;
    endcase
  end

  div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .q_raw    (q_q),
    .r_raw    (r_q),
    .dividend (dividend_q),
    .neg_q    (neg_q_q),
    .neg_r    (neg_r_q),
    .div_zero (div_zero_q),
    .sign_ovf (sign_ovf_q),
    .quot_c   (quot_c),
    .rem_c    (rem_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q        <= '0;
      q_q        <= '0;
      d_mag_q    <= '0;
      dividend_q <= '0;
      cnt_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      sign_ovf_q <= 1'b0;
      Quot       <= '0;
      Rem        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load_c) begin
        r_q        <= '0;
        q_q        <= a_mag_c;
        d_mag_q    <= b_mag_c;
        dividend_q <= SrcA;
        cnt_q      <= CW'(WIDTH);
        neg_q_q    <= a_neg_c ^ b_neg_c;
        neg_r_q    <= a_neg_c;
        div_zero_q <= div_zero_c;
        sign_ovf_q <= sign_ovf_c;
        busy       <= 1'b1;
      end
      if (step_c) begin
        if (!trial_c[WIDTH]) begin
          r_q <= trial_c[WIDTH-1:0];
          q_q <= {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_q <= {r_q[WIDTH-2:0], q_q[WIDTH-1]};
          q_q <= {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_q <= cnt_q - CW'(1);
      end
      if (finish_c) begin
        Quot <= quot_c;
        Rem  <= rem_c;
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (honours DIV_FAST_SPECIAL_EN).
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int NORM_LAT = 33;
`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] SrcA, SrcB;
  logic        is_signed, start;
  logic [31:0] Quot, Rem;
  logic        busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic saw_done;

  seq_divider dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .is_signed (is_signed),
    .start     (start),
    .Quot      (Quot),
    .Rem       (Rem),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, leave inputs quiet afterwards
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    SrcA = a; SrcB = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges after the accept edge until done is seen (bounded)
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er,
                        input int elat);
    int n;
    issue(a, b, s);
    chk({tag, ".busy_acc"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({tag, ".lat"}, 32'(n), 32'(elat));
    chk({tag, ".quot"}, Quot, eq);
    chk({tag, ".rem"}, Rem, er);
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".done_clr"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; SrcA = '0; SrcB = '0; is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.quot", Quot, 32'd0);
    chk("rst.rem", Rem, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    @(negedge clk); reset_n = 1'b1;

    run_op("udiv100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, NORM_LAT);
    run_op("sdiv-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, NORM_LAT);
    run_op("sdiv7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, NORM_LAT);
    run_op("sdiv-8_-3", 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 32'd2, 32'hFFFF_FFFE, NORM_LAT);
    run_op("udivmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, NORM_LAT);
    run_op("udiv0", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, SPEC_LAT);
    run_op("sdiv0", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, SPEC_LAT);
    run_op("sdiv0neg", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, SPEC_LAT);
    run_op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, SPEC_LAT);
    run_op("uovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, NORM_LAT);

    // Second start while busy must be ignored
    issue(32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    SrcA = 32'd50; SrcB = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    chk("busy_ign.lat", 32'(lat + 6), 32'(NORM_LAT));
    chk("busy_ign.quot", Quot, 32'd14);
    chk("busy_ign.rem", Rem, 32'd2);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("busy_ign.no_extra", 32'(saw_done), 32'd0);

    // Start presented on the done cycle is accepted
    issue(32'd100, 32'd7, 1'b0);
    wait_done(lat);
    chk("b2b.first_quot", Quot, 32'd14);
    SrcA = 32'd1000; SrcB = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b.busy_acc", 32'(busy), 32'd1);
    wait_done(lat);
    chk("b2b.lat", 32'(lat), 32'(NORM_LAT));
    chk("b2b.quot", Quot, 32'd333);
    chk("b2b.rem", Rem, 32'd1);

    // Reset at CALC iteration 10 aborts the operation
    issue(32'd12345, 32'd10, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort.quot", Quot, 32'd0);
    chk("abort.rem", Rem, 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("abort.no_done", 32'(saw_done), 32'd0);
    run_op("post_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, NORM_LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
